mem_io_bridge: RTL and testbench

Sits between the processor's data-memory port and the data RAM. Decodes each data access as RAM or memory-mapped I/O and forwards RAM traffic unchanged. Serves the MMIO window locally:
- an 8-entry character TX FIFO drained over a valid/ready handshake,
- a coherent 64-bit free-running cycle counter,
- a sticky halt register used to end simulation runs.

---
 rtl/mem_io_bridge_pkg.sv | 26 ++
 rtl/mem_io_bridge_if.sv | 37 +++
 rtl/mem_io_bridge_char.sv | 51 +++++
 rtl/mem_io_bridge.sv | 129 ++++++++++++
 tb/tb_mem_io_bridge.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_bridge_pkg.sv
// Shared definitions for the data-memory / MMIO bridge: register offsets,
// STATUS bit positions, read-source select and the window decode helper.
package mem_io_bridge_pkg;

   localparam logic [7:0] OFF_TX     = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_CNT_LO = 8'h08;
   localparam logic [7:0] OFF_CNT_HI = 8'h0C;
   localparam logic [7:0] OFF_HALT   = 8'h10;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 4;

   typedef enum logic {
      SEL_RAM  = 1'b0,
      SEL_MMIO = 1'b1
   } sel_e;

   // The window is one 256 MB region selected by the top address nibble.
   function automatic logic in_window(input logic [3:0] addr_hi, input logic [3:0] base_hi);
      return addr_hi == base_hi;
   endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// Core-side, RAM-side and peripheral-side signals of the bridge.
// The bridge takes the slave view; the core/RAM/sink environment takes the master view.
interface mem_io_bridge_if;

   logic        read;
   logic [31:0] read_address;
   logic [3:0]  write;
   logic [31:0] write_address;
   logic [31:0] DATA_out;
   logic [31:0] DATA_in;

   logic        ram_read;
   logic [31:0] ram_read_address;
   logic [3:0]  ram_write;
   logic [31:0] ram_write_address;
   logic [31:0] ram_data_out;
   logic [31:0] ram_data_in;

   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        halt;
   logic [31:0] halt_code;

   modport slave (
      input  read, read_address, write, write_address, DATA_out, ram_data_in, tx_ready,
      output DATA_in, ram_read, ram_read_address, ram_write, ram_write_address, ram_data_out,
      output tx_data, tx_valid, halt, halt_code
   );

   modport master (
      output read, read_address, write, write_address, DATA_out, ram_data_in, tx_ready,
      input  DATA_in, ram_read, ram_read_address, ram_write, ram_write_address, ram_data_out,
      input  tx_data, tx_valid, halt, halt_code
   );

endinterface

// File: rtl/mem_io_bridge_char.sv
// Synchronous character FIFO; a push on full is accepted only alongside a pop,
// otherwise it is dropped and flagged on o_drop for that cycle. Head reads 0 when empty.
module char_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_drop
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB tells full from empty when the index bits match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_drop    = i_push & ~w_do_push;
   assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/mem_io_bridge.sv
// Splits core data accesses between the RAM and a local MMIO window holding a TX FIFO,
// a 64-bit cycle counter with coherent high-word shadow, and a sticky halt register.
module mem_io_bridge
   import mem_io_bridge_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
   input  logic           clk,
   input  logic           reset,
   mem_io_bridge_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          w_rd_mmio;
   logic          w_wr_mmio;
   logic [7:0]    w_rd_off;
   logic [7:0]    w_wr_off;
   logic          w_mmio_rd;
   logic          w_push;
   logic          w_drop;
   logic          w_halt_wr;
   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_head;
   logic [CW-1:0] w_count;
   logic [31:0]   w_status;
   logic [31:0]   w_mmio_rdata;

   logic [63:0]   r_cnt;
   logic [31:0]   r_shadow;
   logic [31:0]   r_mmio_rdata;
   logic [31:0]   r_halt_code;
   logic          r_ovf;
   logic          r_halt;
   sel_e          r_sel;

   assign w_rd_mmio = in_window(bus.read_address[31:28], MMIO_BASE[31:28]);
   assign w_wr_mmio = in_window(bus.write_address[31:28], MMIO_BASE[31:28]);
   assign w_rd_off  = bus.read_address[7:0];
   assign w_wr_off  = bus.write_address[7:0];
   assign w_mmio_rd = bus.read & w_rd_mmio;

   assign bus.ram_read          = bus.read & ~w_rd_mmio;
   assign bus.ram_read_address  = bus.read_address;
   assign bus.ram_write         = w_wr_mmio ? 4'b0000 : bus.write;
   assign bus.ram_write_address = bus.write_address;
   assign bus.ram_data_out      = bus.DATA_out;

   assign w_push    = w_wr_mmio && (w_wr_off == OFF_TX) && bus.write[0];
   assign w_halt_wr = w_wr_mmio && (w_wr_off == OFF_HALT) && (|bus.write);

   char_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_char_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (bus.DATA_out[7:0]),
      .i_pop      (bus.tx_ready),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count),
      .o_drop     (w_drop)
   );

   assign bus.tx_data  = w_head;
   assign bus.tx_valid = ~w_empty;

   // A drop in the same cycle as a STATUS read must already be visible to that read.
   always_comb begin
      w_status           = (32'(w_count) & 32'h0000_000F) << ST_CNT_LSB;
      w_status[ST_FULL]  = w_full;
      w_status[ST_EMPTY] = w_empty;
      w_status[ST_OVF]   = r_ovf | w_drop;
   end

   always_comb begin
      w_mmio_rdata = 32'h0;
      case (w_rd_off)
         OFF_STATUS: w_mmio_rdata = w_status;
         OFF_CNT_LO: w_mmio_rdata = r_cnt[31:0];
         OFF_CNT_HI: w_mmio_rdata = r_shadow;
         default:    w_mmio_rdata = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= '0;
         r_shadow     <= '0;
         r_mmio_rdata <= '0;
         r_ovf        <= 1'b0;
         r_halt       <= 1'b0;
         r_halt_code  <= '0;
         r_sel        <= SEL_RAM;
      end else begin
         r_cnt <= r_cnt + 64'd1;

         if (bus.read) begin
            r_sel <= w_rd_mmio ? SEL_MMIO : SEL_RAM;
         end
         if (w_mmio_rd) begin
            r_mmio_rdata <= w_mmio_rdata;
         end
         if (w_mmio_rd && (w_rd_off == OFF_CNT_LO)) begin
            r_shadow <= r_cnt[63:32];
         end

         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_mmio_rd && (w_rd_off == OFF_STATUS)) begin
            r_ovf <= 1'b0;
         end

         if (w_halt_wr && !r_halt) begin
            r_halt      <= 1'b1;
            r_halt_code <= bus.DATA_out;
         end
      end
   end

   assign bus.DATA_in   = (r_sel == SEL_MMIO) ? r_mmio_rdata : bus.ram_data_in;
   assign bus.halt      = r_halt;
   assign bus.halt_code = r_halt_code;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: expected read data and TX bytes are queued
// when stimulus is driven and compared when the bridge produces them.
module tb_mem_io_bridge;

   localparam logic [31:0] MB = 32'h8000_0000;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   logic [31:0] rd_q[$];
   string       rd_tag_q[$];
   logic [7:0]  tx_q[$];
   logic        rd_pend;

   mem_io_bridge_if bus();

   mem_io_bridge #(
      .FIFO_DEPTH (8),
      .MMIO_BASE  (32'h8000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_dat(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Read data appears one cycle after the read is presented.
   always @(negedge clk) begin
      if (rd_pend) begin
         if (rd_q.size() == 0) check_dat("rd_unexpected", 32'd1, 32'd0);
         else check_dat(rd_tag_q.pop_front(), bus.DATA_in, rd_q.pop_front());
      end
      rd_pend <= bus.read && !reset;
   end

   // A byte is consumed on each cycle with tx_valid and tx_ready both high.
   always @(negedge clk) begin
      if (bus.tx_valid && bus.tx_ready && !reset) begin
         if (tx_q.size() == 0) check_dat("tx_unexpected", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
         else check_dat("tx_byte", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag, input logic exp_ram_rd);
      bus.read         = 1'b1;
      bus.read_address = a;
      rd_q.push_back(exp);
      rd_tag_q.push_back(tag);
      #1;
      check_dat({tag, "_ram_read"}, {31'h0, bus.ram_read}, {31'h0, exp_ram_rd});
      check_dat({tag, "_ram_raddr"}, bus.ram_read_address, a);
      tick(1);
      bus.read = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [3:0] exp_we);
      bus.write         = be;
      bus.write_address = a;
      bus.DATA_out      = d;
      #1;
      check_dat("ram_write", {28'h0, bus.ram_write}, {28'h0, exp_we});
      check_dat("ram_wdata", bus.ram_data_out, d);
      tick(1);
      bus.write = 4'b0000;
   endtask

   task automatic rdwr(input logic [31:0] ra, input logic [31:0] exp, input string tag,
                       input logic [31:0] wa, input logic [31:0] d);
      bus.read          = 1'b1;
      bus.read_address  = ra;
      bus.write         = 4'b0001;
      bus.write_address = wa;
      bus.DATA_out      = d;
      rd_q.push_back(exp);
      rd_tag_q.push_back(tag);
      tick(1);
      bus.read  = 1'b0;
      bus.write = 4'b0000;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rd_pend = 1'b0;
      reset = 1'b1;
      bus.read = 1'b0;
      bus.read_address = '0;
      bus.write = 4'b0000;
      bus.write_address = '0;
      bus.DATA_out = '0;
      bus.ram_data_in = '0;
      bus.tx_ready = 1'b0;
      tick(3);

      check_dat("rst_data_in", bus.DATA_in, 32'h0);
      check_dat("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      check_dat("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
      check_dat("rst_halt", {31'h0, bus.halt}, 32'h0);
      check_dat("rst_halt_code", bus.halt_code, 32'h0);
      reset = 1'b0;

      // Counter starts at 0 on the first cycle out of reset.
      rd(MB | 32'h08, 32'h0, "cnt_lo_rst", 1'b0);
      rd(MB | 32'h0C, 32'h0, "cnt_hi_rst", 1'b0);
      rd(MB | 32'h08, 32'h2, "cnt_lo_run", 1'b0);
      rd(32'h8123_4504, 32'h0000_0002, "status_rst", 1'b0);

      // RAM pass-through.
      bus.ram_data_in = 32'hDEAD_BEEF;
      rd(32'h0000_0100, 32'hDEAD_BEEF, "ram_rd", 1'b1);
      wr(32'h0000_0200, 32'h1234_5678, 4'b0011, 4'b0011);
      check_dat("ram_waddr", bus.ram_write_address, 32'h0000_0200);

      // Three pushes, then drain.
      wr(MB, 32'h41, 4'b0001, 4'b0000);
      wr(MB, 32'h42, 4'b0001, 4'b0000);
      wr(MB, 32'h43, 4'b0001, 4'b0000);
      tx_q.push_back(8'h41);
      tx_q.push_back(8'h42);
      tx_q.push_back(8'h43);
      rd(MB | 32'h04, 32'h0000_0030, "status_cnt3", 1'b0);
      bus.tx_ready = 1'b1;
      tick(3);
      check_dat("drain3_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      check_dat("drain3_q", rd_q.size() == 0 ? 32'h0 : 32'h1, 32'h0);
      check_dat("drain3_txq", tx_q.size(), 32'h0);
      bus.tx_ready = 1'b0;

      // Nine pushes into an 8-entry FIFO: the ninth is dropped.
      for (int i = 0; i < 9; i++) begin
         wr(MB, 32'h30 + i, 4'b0001, 4'b0000);
         if (i < 8) tx_q.push_back(8'(8'h30 + i));
      end
      rd(MB | 32'h04, 32'h0000_0085, "status_ovf", 1'b0);
      rd(MB | 32'h04, 32'h0000_0081, "status_ovf_clr", 1'b0);

      // Push on full with a simultaneous pop is accepted.
      bus.tx_ready = 1'b1;
      wr(MB, 32'h5A, 4'b0001, 4'b0000);
      tx_q.push_back(8'h5A);
      bus.tx_ready = 1'b0;
      rd(MB | 32'h04, 32'h0000_0081, "status_full_pop", 1'b0);

      // STATUS read together with an overflowing push.
      rdwr(MB | 32'h04, 32'h0000_0085, "status_rd_ovf_same", MB, 32'h40);
      rd(MB | 32'h04, 32'h0000_0085, "status_ovf_sticky", 1'b0);
      rd(MB | 32'h04, 32'h0000_0081, "status_ovf_clr2", 1'b0);

      bus.tx_ready = 1'b1;
      tick(8);
      check_dat("drain8_tx_valid", {31'h0, bus.tx_valid}, 32'h0);

      // Push and pop requested together on an empty FIFO: no bypass.
      bus.write         = 4'b0001;
      bus.write_address = MB;
      bus.DATA_out      = 32'h51;
      #1;
      check_dat("bypass_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      tx_q.push_back(8'h51);
      tick(1);
      bus.write = 4'b0000;
      check_dat("bypass_next_valid", {31'h0, bus.tx_valid}, 32'h1);
      check_dat("bypass_next_data", {24'h0, bus.tx_data}, 32'h51);
      tick(1);
      check_dat("bypass_drained", {31'h0, bus.tx_valid}, 32'h0);
      bus.tx_ready = 1'b0;

      // Counter coherency across the 32-bit wrap.
      force dut.r_cnt = 64'h0000_0000_FFFF_FFFF;
      #1;
      release dut.r_cnt;
      rd(MB | 32'h08, 32'hFFFF_FFFF, "cnt_lo_wrap", 1'b0);
      rd(MB | 32'h0C, 32'h0000_0000, "cnt_hi_wrap", 1'b0);
      rd(MB | 32'h08, 32'h0000_0001, "cnt_lo_after", 1'b0);
      rd(MB | 32'h0C, 32'h0000_0001, "cnt_hi_after", 1'b0);
      rd(MB | 32'h20, 32'h0000_0000, "unmapped_rd", 1'b0);

      // Halt: only the first write counts.
      wr(MB | 32'h10, 32'h0000_002A, 4'b1111, 4'b0000);
      check_dat("halt_set", {31'h0, bus.halt}, 32'h1);
      check_dat("halt_code", bus.halt_code, 32'h2A);
      wr(MB | 32'h10, 32'h0000_0001, 4'b0001, 4'b0000);
      check_dat("halt_sticky", {31'h0, bus.halt}, 32'h1);
      check_dat("halt_code_kept", bus.halt_code, 32'h2A);

      // Reset with four bytes queued.
      for (int i = 0; i < 4; i++) wr(MB, 32'h61 + i, 4'b0001, 4'b0000);
      check_dat("q4_tx_valid", {31'h0, bus.tx_valid}, 32'h1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_dat("rst2_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      check_dat("rst2_tx_data", {24'h0, bus.tx_data}, 32'h0);
      check_dat("rst2_halt", {31'h0, bus.halt}, 32'h0);
      check_dat("rst2_halt_code", bus.halt_code, 32'h0);
      rd(MB | 32'h04, 32'h0000_0002, "status_rst2", 1'b0);
      tick(2);

      check_dat("rd_q_left", rd_q.size(), 32'h0);
      check_dat("tx_q_left", tx_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
